// File: rtl/bitstream_loader.sv
// bitstream_loader: streams configuration words LSB first into a serial
// scan chain of CHAIN_LEN bits, requesting words over a valid/ready handshake.
// Optional feature: define BITSTREAM_LOADER_CRC_EN to add an 8-bit CRC
// (poly 0x07) of every bit shifted into the chain, exposed on port crc.
module bitstream_loader #(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  scan_out,
  output logic                  scan_en,
  output logic                  busy,
  output logic                  done
`ifdef BITSTREAM_LOADER_CRC_EN
  ,
  output logic [7:0]            crc
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        bit_cnt;   // bits already shifted into the chain
  logic [IDX_W-1:0]        bit_idx;   // position of scan_out within current word
  logic [WORD_WIDTH-1:0]   shreg;     // bits of the current word not yet presented
  logic                    kill;
  logic                    chain_last;
  logic                    last_bit;

`ifdef BITSTREAM_LOADER_CRC_EN
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction
`endif

  assign kill       = abort && (state != IDLE);
  // The bit on scan_out this cycle is the final one of the chain or of the word.
  assign chain_last = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign last_bit   = chain_last || (bit_idx == IDX_W'(WORD_WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (start)      state_nxt = WAIT_WORD;
        WAIT_WORD: if (word_valid) state_nxt = SHIFT;
        SHIFT:     if (last_bit)   state_nxt = chain_last ? DONE : WAIT_WORD;
        DONE:                      state_nxt = IDLE;
        default:                   state_nxt = IDLE;
      endcase
    end
  end

  // State-decoded status outputs.
  always_comb begin
    word_ready = (state == WAIT_WORD);
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

  // Shift datapath: scan_out/scan_en are registered so the chain sees clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      scan_en  <= 1'b0;
      scan_out <= 1'b0;
`ifdef BITSTREAM_LOADER_CRC_EN
      crc      <= 8'h00;
`endif
    end else begin
      scan_en  <= 1'b0;
      scan_out <= 1'b0;
      if (!kill) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              bit_cnt <= '0;
`ifdef BITSTREAM_LOADER_CRC_EN
              crc     <= 8'h00;
`endif
            end
          end
          WAIT_WORD: begin
            if (word_valid) begin
              shreg    <= word_data >> 1;
              scan_out <= word_data[0];
              scan_en  <= 1'b1;
              bit_idx  <= '0;
            end
          end
          SHIFT: begin
            bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef BITSTREAM_LOADER_CRC_EN
            crc     <= crc_step(crc, scan_out);
`endif
            if (!last_bit) begin
              scan_en  <= 1'b1;
              scan_out <= shreg[0];
              shreg    <= shreg >> 1;
              bit_idx  <= bit_idx + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader: instance a (CHAIN_LEN=16), instance b
// (CHAIN_LEN=12) and, with BITSTREAM_LOADER_CRC_EN, instance c (CHAIN_LEN=8).
module tb_bitstream_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] word_data = 8'h00;
  logic       word_valid = 1'b0;

  logic a_ready, a_out, a_en, a_busy, a_done;
  logic b_ready, b_out, b_en, b_busy, b_done;
  logic c_ready, c_out, c_en, c_busy, c_done;
  logic [7:0] c_crc;

  int total = 0;
  int bad = 0;
  int sel = 0;
  int en_cnt, done_cnt, acc;
  logic [31:0] cap;
  logic [7:0]  crc_at_done;

  logic s_ready, s_out, s_en, s_busy, s_done;

  always #5 clk = ~clk;

  bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LEN(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(a_ready),
    .scan_out(a_out), .scan_en(a_en), .busy(a_busy), .done(a_done)
`ifdef BITSTREAM_LOADER_CRC_EN
    , .crc()
`endif
  );

  bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LEN(12)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(b_ready),
    .scan_out(b_out), .scan_en(b_en), .busy(b_busy), .done(b_done)
`ifdef BITSTREAM_LOADER_CRC_EN
    , .crc()
`endif
  );

`ifdef BITSTREAM_LOADER_CRC_EN
  bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LEN(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(c_ready),
    .scan_out(c_out), .scan_en(c_en), .busy(c_busy), .done(c_done),
    .crc(c_crc)
  );
`else
  assign {c_ready, c_out, c_en, c_busy, c_done} = 5'b0;
  assign c_crc = 8'h00;
`endif

  // Select which instance the load helper observes.
  always_comb begin
    case (sel)
      1:       {s_ready, s_out, s_en, s_busy, s_done} = {b_ready, b_out, b_en, b_busy, b_done};
      2:       {s_ready, s_out, s_en, s_busy, s_done} = {c_ready, c_out, c_en, c_busy, c_done};
      default: {s_ready, s_out, s_en, s_busy, s_done} = {a_ready, a_out, a_en, a_busy, a_done};
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; word_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Runs one full load on the selected instance, recording shifted bits.
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1,
                          input int nwords, input int stall);
    int stall_left;
    stall_left = stall;
    en_cnt = 0; done_cnt = 0; acc = 0; cap = '0; crc_at_done = 8'hxx;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (!(s_busy === 1'b1 && s_ready === 1'b1)) begin
      bad++;
      $display("FAIL start_to_wait busy=%b ready=%b required busy=1 ready=1", s_busy, s_ready);
    end
    for (int c = 0; c < 100; c++) begin
      if (s_ready && acc < nwords) begin
        if (acc == 1 && stall_left > 0) begin
          word_valid = 1'b0;
          step();
          stall_left--;
          total++;
          if (!(s_en === 1'b0 && s_ready === 1'b1)) begin
            bad++;
            $display("FAIL stall_hold en=%b ready=%b required en=0 ready=1", s_en, s_ready);
          end
          continue;
        end
        word_valid = 1'b1;
        word_data  = (acc == 0) ? w0 : w1;
        step();
        acc++;
        word_valid = 1'b0;
      end else begin
        word_valid = 1'b0;
        step();
      end
      if (s_en === 1'b1 && en_cnt < 32) begin
        cap[en_cnt] = s_out;
        en_cnt++;
      end
      if (s_done === 1'b1) begin
        done_cnt++;
        crc_at_done = c_crc;
      end
      if (done_cnt > 0 && s_busy === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_ready, a_out, a_en, a_busy, a_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_a outputs=%b required=00000", {a_ready, a_out, a_en, a_busy, a_done});
    end
    total++;
    if ({b_ready, b_out, b_en, b_busy, b_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_b outputs=%b required=00000", {b_ready, b_out, b_en, b_busy, b_done});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    sel = 0;
    do_reset();
    run_load(8'hA5, 8'h3C, 2, 0);
    total++;
    if (cap[15:0] !== 16'h3CA5) begin
      bad++;
      $display("FAIL basic_bits got=%h required=3ca5", cap[15:0]);
    end
    total++;
    if (en_cnt !== 16) begin
      bad++;
      $display("FAIL basic_en_cycles got=%0d required=16", en_cnt);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL basic_done got=%0d required=1", done_cnt);
    end
  endtask

  task automatic test_partial_word();
    sel = 1;
    do_reset();
    run_load(8'hFF, 8'hFF, 2, 0);
    total++;
    if (en_cnt !== 12) begin
      bad++;
      $display("FAIL partial_en_cycles got=%0d required=12", en_cnt);
    end
    total++;
    if (cap[15:0] !== 16'h0FFF) begin
      bad++;
      $display("FAIL partial_bits got=%h required=0fff", cap[15:0]);
    end
    total++;
    if (done_cnt !== 1 || acc !== 2) begin
      bad++;
      $display("FAIL partial_done done=%0d words=%0d required done=1 words=2", done_cnt, acc);
    end
  endtask

  task automatic test_stall();
    sel = 0;
    do_reset();
    run_load(8'hA5, 8'h3C, 2, 5);
    total++;
    if (cap[15:0] !== 16'h3CA5 || en_cnt !== 16) begin
      bad++;
      $display("FAIL stall_resume bits=%h en=%0d required bits=3ca5 en=16", cap[15:0], en_cnt);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL stall_done got=%0d required=1", done_cnt);
    end
  endtask

  task automatic test_abort();
    int seen_done;
    sel = 0;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    word_valid = 1'b1;
    word_data = 8'hA5;
    step();
    word_valid = 1'b0;
    step(); step(); step();
    total++;
    if (!(a_en === 1'b1 && a_out === 1'b0)) begin
      bad++;
      $display("FAIL abort_bit3 en=%b out=%b required en=1 out=0", a_en, a_out);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if ({a_busy, a_en, a_out, a_done} !== 4'b0) begin
      bad++;
      $display("FAIL abort_idle busy/en/out/done=%b required=0000", {a_busy, a_en, a_out, a_done});
    end
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (a_done === 1'b1 || a_busy === 1'b1) seen_done++;
    end
    total++;
    if (seen_done !== 0) begin
      bad++;
      $display("FAIL abort_no_done activity=%0d required=0", seen_done);
    end
    run_load(8'hA5, 8'h3C, 2, 0);
    total++;
    if (cap[15:0] !== 16'h3CA5 || en_cnt !== 16 || done_cnt !== 1) begin
      bad++;
      $display("FAIL abort_reload bits=%h en=%0d done=%0d required 3ca5/16/1", cap[15:0], en_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid_shift();
    int stray;
    sel = 0;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    word_valid = 1'b1;
    word_data = 8'hA5;
    step();
    word_valid = 1'b0;
    start = 1'b1;
    step();
    total++;
    if (!(a_busy === 1'b1 && a_en === 1'b1 && a_out === 1'b0)) begin
      bad++;
      $display("FAIL start_ignored busy=%b en=%b out=%b required 1/1/0", a_busy, a_en, a_out);
    end
    step();
    start = 1'b0;
    total++;
    if (!(a_en === 1'b1 && a_out === 1'b1)) begin
      bad++;
      $display("FAIL pre_reset_bit2 en=%b out=%b required 1/1", a_en, a_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_ready, a_out, a_en, a_busy, a_done} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset outputs=%b required=00000", {a_ready, a_out, a_en, a_busy, a_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    word_valid = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_busy !== 1'b0 || a_en !== 1'b0 || a_ready !== 1'b0) stray++;
    end
    word_valid = 1'b0;
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL no_resume active_cycles=%0d required=0", stray);
    end
  endtask

  task automatic test_crc();
`ifdef BITSTREAM_LOADER_CRC_EN
    sel = 2;
    do_reset();
    run_load(8'h01, 8'h00, 1, 0);
    total++;
    if (crc_at_done !== 8'h89 || en_cnt !== 8) begin
      bad++;
      $display("FAIL crc_01 crc=%h en=%0d required crc=89 en=8", crc_at_done, en_cnt);
    end
    run_load(8'h00, 8'h00, 1, 0);
    total++;
    if (crc_at_done !== 8'h00 || done_cnt !== 1) begin
      bad++;
      $display("FAIL crc_00 crc=%h done=%0d required crc=00 done=1", crc_at_done, done_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_word();
    test_stall();
    test_abort();
    test_reset_mid_shift();
    test_crc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitstream_loader.md
BITSTREAM_LOADER -- requirements
Module: bitstream_loader

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 8, giving the configuration word width in bits.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 64, giving the total scan-chain length in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begin a load; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel the load in progress.
REQ-007 The block SHALL have port word_data, input, WORD_WIDTH bits: configuration word, shifted LSB first.
REQ-008 The block SHALL have port word_valid, input, 1 bit: word_data is valid.
REQ-009 The block SHALL have port word_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-010 The block SHALL have port scan_out, output, 1 bit: serial data to the scan_in of the first chain element.
REQ-011 The block SHALL have port scan_en, output, 1 bit: chain shift enable.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when the load completes.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WAIT_WORD, SHIFT, DONE.
REQ-015 In IDLE with start=1, the FSM SHALL clear the bit counter and enter WAIT_WORD on the next edge; start outside IDLE SHALL be ignored.
REQ-016 word_ready SHALL be high only in WAIT_WORD; a word is accepted on an edge where word_valid=1 and word_ready=1, and the FSM then enters SHIFT.
REQ-017 In SHIFT, scan_en SHALL be 1 and scan_out SHALL equal bit k of the accepted word on the k-th SHIFT cycle (k=0 first); both are registered outputs.
REQ-018 The chain SHALL treat each cycle with scan_en=1 as one shift; the count of such cycles from start to done SHALL equal CHAIN_LEN exactly.
REQ-019 SHIFT SHALL exit after WORD_WIDTH bits or when the total bit count reaches CHAIN_LEN, whichever occurs first; remaining bits of a partial last word SHALL be discarded.
REQ-020 On SHIFT exit, the FSM SHALL enter DONE if the total equals CHAIN_LEN, otherwise WAIT_WORD; in WAIT_WORD, scan_en SHALL be 0 so the chain holds.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with scan_en=0 and without a done pulse; abort SHALL take priority over a simultaneous word handshake or SHIFT exit.
REQ-024 In IDLE, scan_en SHALL be 0 and scan_out SHALL be 0.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force state IDLE, counter 0, shift register 0, and scan_en, scan_out, word_ready, busy and done to 0, including during a load in progress.
REQ-026 After rst_n is released, the block SHALL wait for a new start; it SHALL NOT resume a load that was interrupted by reset.

Configuration
REQ-027 With macro BITSTREAM_LOADER_CRC_EN defined, the block SHALL add output crc[7:0], cleared to 0x00 at start and reset.
REQ-028 With BITSTREAM_LOADER_CRC_EN defined, crc SHALL update on each shifted bit b as crc = {crc[6:0],0} XOR (crc[7]^b ? 0x07 : 0x00).
REQ-029 Without BITSTREAM_LOADER_CRC_EN, the crc port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: WORD_WIDTH=8, CHAIN_LEN=16, words 0xA5 then 0x3C -> scan_out sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; 16 scan_en cycles; one done pulse.
REQ-031 The bench SHALL cover: CHAIN_LEN=12, words 0xFF then 0xFF -> exactly 12 scan_en cycles; the upper 4 bits of the second word are discarded; then done.
REQ-032 The bench SHALL cover: word_valid held low for 5 cycles mid-load -> scan_en=0 and word_ready=1 throughout, and the load resumes correctly afterwards.
REQ-033 The bench SHALL cover: abort asserted at SHIFT bit 3 -> IDLE next cycle, scan_en=0, no done; a fresh start then loads normally.
REQ-034 The bench SHALL cover: rst_n pulsed low mid-SHIFT -> all outputs 0 asynchronously, and start is ignored while busy.
REQ-035 The bench SHALL cover: with BITSTREAM_LOADER_CRC_EN, CHAIN_LEN=8, word 0x01 -> crc=0x89 at done; with word 0x00 -> crc=0x00.
